burst_slot_sender: RTL and testbench

- Downstream AXI write-issue stage fed by the special memory's burst release path (tran_valid/tran_ready plus a complete burst_slot).
- Accepts one fully buffered burst, drives its AW beat, then serialises the data/strobe arrays into W beats with wlast, then waits for the B response.
- Lowers tran_ready for the whole burst; the upstream slot-delete logic keys on that falling edge.

---
 rtl/burst_slot_sender_pkg.sv | 42 ++++
 rtl/burst_slot_sender.sv | 150 +++++++++++++++
 tb/tb_burst_slot_sender.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_slot_sender_pkg.sv
// Shared types and constants for the burst slot sender and the special memory
// that feeds it: slot layout, AXI response codes, awuser encodings, FSM states.
package burst_slot_sender_pkg;

  localparam int PID_WIDTH      = 4;
  localparam int PADDR_WIDTH    = 32;
  localparam int PDATA_WIDTH    = 8;
  localparam int PMAX_BEATS     = 16;
  localparam int PSTRB_WIDTH    = (PDATA_WIDTH / 8 < 1) ? 1 : PDATA_WIDTH / 8;
  localparam int PCOMPLETE_DATA = PDATA_WIDTH * PMAX_BEATS;
  localparam int PCOMPLETE_STRB = PSTRB_WIDTH * PMAX_BEATS;
  localparam int PAWUSER_WIDTH  = 2;
  localparam int POTHER_WIDTH   = 8;

  localparam logic [PAWUSER_WIDTH-1:0] AWUSER_NORMAL = 2'b00;
  localparam logic [PAWUSER_WIDTH-1:0] AWUSER_DIVERT = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [PID_WIDTH-1:0]      awid;
    logic [PADDR_WIDTH-1:0]    awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [PAWUSER_WIDTH-1:0]  awuser;
    logic [POTHER_WIDTH-1:0]   other;
    logic [PCOMPLETE_DATA-1:0] data;
    logic [PCOMPLETE_STRB-1:0] strb;
  } burst_slot;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } sender_state_e;

endpackage

// File: rtl/burst_slot_sender.sv
// AXI write-issue stage: takes one buffered burst_slot, issues AW, serialises W
// beats, then collects B. Optional B-wait timeout via BURST_SENDER_RESP_TIMEOUT_EN.
module burst_slot_sender
  import burst_slot_sender_pkg::*;
#(
  parameter int ID_WIDTH       = PID_WIDTH,
  parameter int ADDR_WIDTH     = PADDR_WIDTH,
  parameter int DATA_WIDTH     = PDATA_WIDTH,
  parameter int MAX_BEATS      = PMAX_BEATS,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tran_valid,
  input  burst_slot                in_slot,
  output logic                     tran_ready,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ID_WIDTH-1:0]      awid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [PAWUSER_WIDTH-1:0] awuser,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [ID_WIDTH-1:0]      wid,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [PSTRB_WIDTH-1:0]   wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready,
  input  logic [1:0]               bresp,
  input  logic [ID_WIDTH-1:0]      bid,
  output logic                     resp_err,
  output logic                     busy
);

  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BEATS - 1);

  sender_state_e state_q, state_d;
  burst_slot     slot_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] last_q;
  logic [BEAT_W-1:0] eff_len_in;
  logic oversize;
  logic accept;
  logic beat_inc;
  logic resp_err_c;
  logic tmo_hit;
  logic unused_other;

  assign oversize   = in_slot.awlen > MAX_LEN;
  assign eff_len_in = oversize ? BEAT_W'(MAX_BEATS - 1) : in_slot.awlen[BEAT_W-1:0];

`ifdef BURST_SENDER_RESP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_RESP) tmo_q <= '0;
    else                          tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == S_RESP) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tran_ready = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    accept     = 1'b0;
    beat_inc   = 1'b0;
    resp_err_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tran_ready = 1'b1;
        if (tran_valid) begin
          accept     = 1'b1;
          resp_err_c = oversize;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = S_DATA;
      end
      S_DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_q == last_q);
        if (wready) begin
          if (wlast) state_d  = S_RESP;
          else       beat_inc = 1'b1;
        end
      end
      S_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d    = S_IDLE;
          resp_err_c = (bresp != AXI_RESP_OKAY) || (bid != slot_q.awid);
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          resp_err_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    resp_err = resp_err_c && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        slot_q <= in_slot;
        beat_q <= '0;
        last_q <= eff_len_in;
      end else if (beat_inc) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign awid    = slot_q.awid;
  assign awaddr  = slot_q.awaddr;
  assign awlen   = slot_q.awlen;
  assign awsize  = slot_q.awsize;
  assign awburst = slot_q.awburst;
  assign awuser  = slot_q.awuser;
  assign wid     = slot_q.awid;
  assign wdata   = slot_q.data[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign wstrb   = slot_q.strb[beat_q*PSTRB_WIDTH +: PSTRB_WIDTH];
  assign busy    = (state_q != S_IDLE);

  assign unused_other = ^slot_q.other;

endmodule

// File: tb/tb_burst_slot_sender.sv
// Directed scoreboard bench for burst_slot_sender; the timeout case is built
// when BURST_SENDER_RESP_TIMEOUT_EN is defined.
module tb_burst_slot_sender;
  import burst_slot_sender_pkg::*;

`ifdef BURST_SENDER_RESP_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic clk = 1'b0;
  logic rst, tran_valid, tran_ready;
  burst_slot in_slot;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, resp_err, busy;
  logic [PID_WIDTH-1:0] awid, wid, bid;
  logic [PADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic [PAWUSER_WIDTH-1:0] awuser;
  logic [PDATA_WIDTH-1:0] wdata;
  logic [PSTRB_WIDTH-1:0] wstrb;

  always #5 clk = ~clk;

  burst_slot_sender #(
    .ID_WIDTH(PID_WIDTH), .ADDR_WIDTH(PADDR_WIDTH), .DATA_WIDTH(PDATA_WIDTH),
    .MAX_BEATS(PMAX_BEATS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .tran_valid(tran_valid), .in_slot(in_slot),
    .tran_ready(tran_ready), .awvalid(awvalid), .awready(awready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awuser(awuser), .wvalid(wvalid), .wready(wready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .resp_err(resp_err), .busy(busy)
  );

  typedef struct {
    logic [PDATA_WIDTH-1:0] data;
    logic [PSTRB_WIDTH-1:0] strb;
    logic                   last;
    logic [PID_WIDTH-1:0]   id;
  } wexp_t;

  typedef struct {
    logic [PADDR_WIDTH-1:0] addr;
    logic [7:0]             len;
    logic [PID_WIDTH-1:0]   id;
  } awexp_t;

  wexp_t  wq[$];
  awexp_t aq[$];
  int errors = 0;
  int checks = 0;
  int w_hs   = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every presented beat against the queue head; pop only on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_err) pulses++;
      if (awvalid) begin
        check("aw_pending", 64'(aq.size() > 0), 64'd1);
        if (aq.size() > 0) begin
          check("awaddr", 64'(awaddr), 64'(aq[0].addr));
          check("awlen", 64'(awlen), 64'(aq[0].len));
          check("awid", 64'(awid), 64'(aq[0].id));
          if (awready) void'(aq.pop_front());
        end
      end
      if (wvalid) begin
        check("w_pending", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          check("wdata", 64'(wdata), 64'(wq[0].data));
          check("wstrb", 64'(wstrb), 64'(wq[0].strb));
          check("wlast", 64'(wlast), 64'(wq[0].last));
          check("wid", 64'(wid), 64'(wq[0].id));
          if (wready) begin
            void'(wq.pop_front());
            w_hs++;
          end
        end
      end
    end
  end

  function automatic burst_slot make_slot(input logic [3:0] id, input logic [31:0] addr,
                                          input logic [7:0] len, input logic [7:0] seed);
    burst_slot s;
    s = '0;
    s.awid    = id;
    s.awaddr  = addr;
    s.awlen   = len;
    s.awsize  = 3'd0;
    s.awburst = 2'b01;
    s.awuser  = AWUSER_DIVERT;
    s.other   = seed;
    for (int i = 0; i < PMAX_BEATS; i++) begin
      s.data[i*PDATA_WIDTH +: PDATA_WIDTH] = seed + 8'(i * 37);
      s.strb[i*PSTRB_WIDTH +: PSTRB_WIDTH] = PSTRB_WIDTH'(i % 3 != 2);
    end
    return s;
  endfunction

  task automatic push_expect(input burst_slot s, output int eff);
    eff = (int'(s.awlen) > PMAX_BEATS - 1) ? PMAX_BEATS - 1 : int'(s.awlen);
    aq.push_back('{s.awaddr, s.awlen, s.awid});
    for (int i = 0; i <= eff; i++)
      wq.push_back('{s.data[i*PDATA_WIDTH +: PDATA_WIDTH],
                     s.strb[i*PSTRB_WIDTH +: PSTRB_WIDTH], i == eff, s.awid});
  endtask

  task automatic run_burst(input string tag, input burst_slot s, input int aw_delay,
                           input bit wtoggle, input logic [1:0] resp,
                           input logic [PID_WIDTH-1:0] rid, input int exp_pulses);
    int eff, cyc, hs0, p0;
    bit done;
    push_expect(s, eff);
    hs0 = w_hs;
    p0  = pulses;
    check({tag, "_ready_idle"}, 64'(tran_ready), 64'd1);
    in_slot = s; tran_valid = 1'b1; awready = 1'b0; wready = 1'b0;
    step();
    tran_valid = 1'b0;
    in_slot    = '1;
    check({tag, "_awvalid_lat"}, 64'(awvalid), 64'd1);
    check({tag, "_ready_low"}, 64'(tran_ready), 64'd0);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 400) begin
      awready = (cyc >= aw_delay);
      wready  = wtoggle ? cyc[0] : 1'b1;
      step();
      cyc++;
      done = bready;
    end
    check({tag, "_resp_reached"}, 64'(done), 64'd1);
    if (aw_delay == 0 && !wtoggle) check({tag, "_cycles"}, 64'(cyc), 64'(eff + 3));
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = resp; bid = rid;
    step();
    bvalid = 1'b0;
    check({tag, "_ready_back"}, 64'(tran_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_beats"}, 64'(w_hs - hs0), 64'(eff + 1));
    check({tag, "_resp_err"}, 64'(pulses - p0), 64'(exp_pulses));
    check({tag, "_w_drained"}, 64'(wq.size()), 64'd0);
    check({tag, "_aw_drained"}, 64'(aq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    burst_slot s;
    int eff, hs0, p0, n;
    rst = 1'b1; tran_valid = 1'b0; in_slot = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    step(); step();
    rst = 1'b0;
    check("rst_tran_ready", 64'(tran_ready), 64'd1);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_wlast", 64'(wlast), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);

    s = make_slot(4'h3, 32'h0000_1000, 8'd0, 8'h00);
    s.data[7:0] = 8'hA5;
    run_burst("single", s, 0, 1'b0, AXI_RESP_OKAY, 4'h3, 0);

    s = make_slot(4'h5, 32'h0000_2040, 8'd3, 8'h00);
    s.data[31:0] = 32'h4433_2211;
    run_burst("bp4", s, 3, 1'b1, AXI_RESP_OKAY, 4'h5, 0);

    s = make_slot(4'h7, 32'h0000_3000, 8'd1, 8'h5C);
    run_burst("slverr", s, 0, 1'b0, AXI_RESP_SLVERR, 4'h7, 1);

    s = make_slot(4'h9, 32'h0000_4000, 8'd2, 8'h81);
    run_burst("bid_mis", s, 0, 1'b0, AXI_RESP_OKAY, 4'h8, 1);

    s = make_slot(4'hA, 32'h0000_5000, 8'(PMAX_BEATS + 2), 8'h13);
    run_burst("oversize", s, 0, 1'b0, AXI_RESP_OKAY, 4'hA, 1);

    s = make_slot(4'h2, 32'h0000_6000, 8'd15, 8'hE0);
    run_burst("full16", s, 1, 1'b1, AXI_RESP_OKAY, 4'h2, 0);

    // Reset part-way through the data phase, after two beats have gone.
    s = make_slot(4'h4, 32'h0000_7000, 8'd3, 8'h27);
    push_expect(s, eff);
    hs0 = w_hs;
    in_slot = s; tran_valid = 1'b1;
    step();
    tran_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    step(); step(); step();
    rst = 1'b1; wready = 1'b0; awready = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_wvalid", 64'(wvalid), 64'd0);
    check("midrst_tran_ready", 64'(tran_ready), 64'd1);
    check("midrst_awvalid", 64'(awvalid), 64'd0);
    check("midrst_beats", 64'(w_hs - hs0), 64'd2);
    wq.delete();
    aq.delete();
    step();
    check("midrst_idle_quiet", 64'({awvalid, wvalid, bready}), 64'd0);
    s = make_slot(4'h6, 32'h0000_8000, 8'd2, 8'h61);
    run_burst("post_rst", s, 0, 1'b0, AXI_RESP_OKAY, 4'h6, 0);

`ifdef BURST_SENDER_RESP_TIMEOUT_EN
    s = make_slot(4'hB, 32'h0000_9000, 8'd0, 8'h3F);
    push_expect(s, eff);
    p0 = pulses;
    in_slot = s; tran_valid = 1'b1;
    step();
    tran_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    n = 0;
    while (!bready && n < 20) begin step(); n++; end
    check("tmo_resp_reached", 64'(bready), 64'd1);
    awready = 1'b0; wready = 1'b0;
    n = 0;
    while (!tran_ready && n < 50) begin step(); n++; end
    check("tmo_cycles", 64'(n), 64'(TMO));
    check("tmo_resp_err", 64'(pulses - p0), 64'd1);
    check("tmo_bready_low", 64'(bready), 64'd0);
    bvalid = 1'b1; bresp = AXI_RESP_OKAY; bid = 4'hB;
    step();
    bvalid = 1'b0;
    check("tmo_late_b_ignored", 64'(pulses - p0), 64'd1);
    check("tmo_idle", 64'(busy), 64'd0);
`else
    p0 = pulses;
    n  = 0;
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
